remote_comm: RTL

// - Host-side counterpart of the command UART link.
// - Serializes a 16-bit command onto TX as two 8N1 bytes: high byte first, then low byte.
// - Deserializes the 8-bit response byte arriving on RX.
// - Self-contained baud generation and shifters (no external UART). Used in testbenches and

---
 rtl/remote_comm.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/remote_comm.sv
// Host-side command UART: sends a 16-bit command as two 8N1 bytes (high first), receives 8-bit responses.
// Optional response timeout counter is built when RESP_TIMEOUT_EN is defined.
module remote_comm #(
    parameter int unsigned BAUD_DIV    = 2604,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    input  logic        RX,
    input  logic        clr_resp_rdy,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        resp_timeout
);

    localparam int unsigned    BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]  HALF_LAST = BW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- transmit path ----------------
    tx_state_t      r_tx_state, w_tx_state_nxt;
    logic [BW-1:0]  r_tx_baud, w_tx_baud_nxt;
    logic [3:0]     r_tx_bit, w_tx_bit_nxt;
    logic [15:0]    r_cmd, w_cmd_nxt;
    logic           r_tx, w_tx_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_cmd_sent, w_sent_nxt;
    logic           w_tx_done;
    logic [7:0]     w_tx_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_cmd      <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_cmd_sent <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_baud  <= w_tx_baud_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_cmd      <= w_cmd_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_cmd_sent <= w_sent_nxt;
        end
    end

    // TX is registered: the next line level is chosen one cycle ahead of each bit boundary
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_baud_nxt  = r_tx_baud;
        w_tx_bit_nxt   = r_tx_bit;
        w_cmd_nxt      = r_cmd;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_sent_nxt     = r_cmd_sent;
        w_tx_done      = 1'b0;
        w_tx_byte      = (r_tx_state == TX_LOW) ? r_cmd[7:0] : r_cmd[15:8];
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_nxt = 1'b1;
                if (snd_cmd) begin
                    w_cmd_nxt      = cmd;
                    w_tx_state_nxt = TX_HIGH;
                    w_tx_baud_nxt  = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_sent_nxt     = 1'b0;
                end
            end
            TX_HIGH, TX_LOW: begin
                if (r_tx_baud == BAUD_LAST) begin
                    w_tx_baud_nxt = '0;
                    if (r_tx_bit == 4'd9) begin
                        w_tx_bit_nxt = '0;
                        if (r_tx_state == TX_HIGH) begin
                            w_tx_state_nxt = TX_LOW;
                            w_tx_nxt       = 1'b0;
                        end else begin
                            w_tx_state_nxt = TX_IDLE;
                            w_tx_nxt       = 1'b1;
                            w_busy_nxt     = 1'b0;
                            w_sent_nxt     = 1'b1;
                            w_tx_done      = 1'b1;
                        end
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 4'd1;
                        w_tx_nxt     = (r_tx_bit < 4'd8) ? w_tx_byte[r_tx_bit[2:0]] : 1'b1;
                    end
                end else begin
                    w_tx_baud_nxt = r_tx_baud + 1'b1;
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
                w_tx_nxt       = 1'b1;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    assign TX       = r_tx;
    assign busy     = r_busy;
    assign cmd_sent = r_cmd_sent;

    // ---------------- receive path ----------------
    logic           r_rx_s1, r_rx_s2, r_rx_s3;
    rx_state_t      r_rx_state, w_rx_state_nxt;
    logic [BW-1:0]  r_rx_baud, w_rx_baud_nxt;
    logic [3:0]     r_rx_bit, w_rx_bit_nxt;
    logic [7:0]     r_rx_shift, w_rx_shift_nxt;
    logic [7:0]     r_resp, w_resp_nxt;
    logic           r_resp_rdy, w_rdy_nxt;
    logic           w_rx_fall;
    logic           w_rx_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_resp     <= '0;
            r_resp_rdy <= 1'b0;
        end else begin
            r_rx_s1    <= RX;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_baud  <= w_rx_baud_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_resp     <= w_resp_nxt;
            r_resp_rdy <= w_rdy_nxt;
        end
    end

    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_baud_nxt  = r_rx_baud;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_resp_nxt     = r_resp;
        w_rx_set       = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_baud_nxt = '0;
                if (w_rx_fall) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_baud == HALF_LAST) begin
                    w_rx_baud_nxt = '0;
                    w_rx_bit_nxt  = '0;
                    w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_baud_nxt = r_rx_baud + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_rx_baud == BAUD_LAST) begin
                    w_rx_baud_nxt  = '0;
                    w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 4'd7) begin
                        w_rx_bit_nxt   = '0;
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 4'd1;
                    end
                end else begin
                    w_rx_baud_nxt = r_rx_baud + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_rx_baud == BAUD_LAST) begin
                    w_rx_baud_nxt  = '0;
                    w_rx_state_nxt = RX_IDLE;
                    if (r_rx_s2) begin
                        w_resp_nxt = r_rx_shift;
                        w_rx_set   = 1'b1;
                    end
                end else begin
                    w_rx_baud_nxt = r_rx_baud + 1'b1;
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
                w_rx_baud_nxt  = '0;
            end
        endcase
    end

    // a new byte wins over a simultaneous clear
    assign w_rdy_nxt = w_rx_set ? 1'b1 : (clr_resp_rdy ? 1'b0 : r_resp_rdy);

    assign resp     = r_resp;
    assign resp_rdy = r_resp_rdy;

    // ---------------- response timeout ----------------
`ifdef RESP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_to_run;
    logic          r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_to_run  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_tx_done) begin
                r_to_run <= 1'b1;
                r_to_cnt <= '0;
            end else if (r_to_run) begin
                if (w_rx_set || snd_cmd) begin
                    r_to_run <= 1'b0;
                end else if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    r_timeout <= 1'b1;
                    r_to_run  <= 1'b0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    assign resp_timeout = r_timeout;
`else
    assign resp_timeout = 1'b0;
`endif

endmodule
